// File: rtl/stopwatch_ctrl_pkg.sv
// rtl/stopwatch_ctrl_pkg.sv - shared mode encodings, default dividers and helpers for the stopwatch controller
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int DEF_TICK_DIV  = 100_000_000;
    localparam int DEF_ADJ_DIV   = 50_000_000;
    localparam int DEF_BLINK_DIV = 25_000_000;
    localparam int DEF_SCAN_DIV  = 390_625;
    localparam int DEF_DB_CYCLES = 1_000_000;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    // A divider of 1 still needs a 1-bit counter.
    function automatic int cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic state_t toggle_run(input state_t s);
        return (s == ST_RUN) ? ST_PAUSED : ST_RUN;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button/switch inputs and command/display outputs of the stopwatch controller
interface stopwatch_ctrl_if;
    import stopwatch_ctrl_pkg::*;

    logic       PAUSE_BTN;
    logic       CLEAR_BTN;
    logic       ADJ;
    logic       SEL;
    logic       TICK;
    logic       INC_SEC;
    logic       INC_MIN;
    logic       CLR_CNT;
    logic [1:0] DIGIT_SEL;
    logic       BLANK_SEC;
    logic       BLANK_MIN;
    state_t     STATE;

    modport slave (
        input  PAUSE_BTN, CLEAR_BTN, ADJ, SEL,
        output TICK, INC_SEC, INC_MIN, CLR_CNT, DIGIT_SEL, BLANK_SEC, BLANK_MIN, STATE
    );

    modport master (
        output PAUSE_BTN, CLEAR_BTN, ADJ, SEL,
        input  TICK, INC_SEC, INC_MIN, CLR_CNT, DIGIT_SEL, BLANK_SEC, BLANK_MIN, STATE
    );

endinterface

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// rtl/stopwatch_ctrl_btn_debounce.sv - 2-flop sync, stability-counter debounce and rising-edge pulse for one button
module btn_debounce
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic CLK,
    input  logic RESET,
    input  logic RAW,
    output logic PULSE
);

    localparam int           W       = cnt_w(DB_CYCLES);
    localparam logic [W-1:0] CNT_MAX = W'(DB_CYCLES - 1);

    logic         r_s1;
    logic         r_s2;
    logic         r_lvl;
    logic         r_lvl_d;
    logic         r_pulse;
    logic [W-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= RAW;
            r_s2    <= r_s1;
            r_lvl_d <= r_lvl;
            r_pulse <= r_lvl & ~r_lvl_d;
            // Any cycle where the synced level agrees with the accepted one restarts the count.
            if (r_s2 == r_lvl) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_lvl <= r_s2;
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
        end
    end

    assign PULSE = r_pulse;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM, tick/adjust prescalers, clear, blink and display scan
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int ADJ_DIV   = DEF_ADJ_DIV,
    parameter int BLINK_DIV = DEF_BLINK_DIV,
    parameter int SCAN_DIV  = DEF_SCAN_DIV,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic            CLK,
    input  logic            RESET,
    stopwatch_ctrl_if.slave io
);

    localparam int TICK_W  = cnt_w(TICK_DIV);
    localparam int ADJ_W   = cnt_w(ADJ_DIV);
    localparam int BLINK_W = cnt_w(BLINK_DIV);
    localparam int SCAN_W  = cnt_w(SCAN_DIV);

    localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(TICK_DIV - 1);
    localparam logic [ADJ_W-1:0]   ADJ_MAX   = ADJ_W'(ADJ_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_MAX  = SCAN_W'(SCAN_DIV - 1);

    logic w_pause_p;
    logic w_clear_p;
    logic w_adj_s;
    logic w_sel_s;
    logic w_adj_entry;

    logic r_adj_s1, r_adj_s2;
    logic r_sel_s1, r_sel_s2;

    state_t r_state;
    state_t r_resume;

    logic [TICK_W-1:0]  r_tick_cnt;
    logic [ADJ_W-1:0]   r_adj_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic [SCAN_W-1:0]  r_scan_cnt;
    logic               r_blink;
    logic               r_tick;
    logic               r_inc_sec;
    logic               r_inc_min;
    logic               r_clr;
    logic               r_blank_sec;
    logic               r_blank_min;
    logic [1:0]         r_digit;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause_db (
        .CLK   (CLK),
        .RESET (RESET),
        .RAW   (io.PAUSE_BTN),
        .PULSE (w_pause_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
        .CLK   (CLK),
        .RESET (RESET),
        .RAW   (io.CLEAR_BTN),
        .PULSE (w_clear_p)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_adj_s1 <= 1'b0;
            r_adj_s2 <= 1'b0;
            r_sel_s1 <= 1'b0;
            r_sel_s2 <= 1'b0;
        end else begin
            r_adj_s1 <= io.ADJ;
            r_adj_s2 <= r_adj_s1;
            r_sel_s1 <= io.SEL;
            r_sel_s2 <= r_sel_s1;
        end
    end

    assign w_adj_s     = r_adj_s2;
    assign w_sel_s     = r_sel_s2;
    assign w_adj_entry = (r_state != ST_ADJUST) && w_adj_s;

    // A pause press that lands with ADJUST entry (or inside ADJUST) only flips where we resume to.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= ST_RUN;
            r_resume <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN, ST_PAUSED: begin
                    if (w_adj_s) begin
                        r_state  <= ST_ADJUST;
                        r_resume <= w_pause_p ? toggle_run(r_state) : r_state;
                    end else if (w_pause_p) begin
                        r_state <= toggle_run(r_state);
                    end
                end
                ST_ADJUST: begin
                    if (!w_adj_s) begin
                        r_state <= w_pause_p ? toggle_run(r_resume) : r_resume;
                    end else if (w_pause_p) begin
                        r_resume <= toggle_run(r_resume);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tick_cnt  <= '0;
            r_adj_cnt   <= '0;
            r_tick      <= 1'b0;
            r_inc_sec   <= 1'b0;
            r_inc_min   <= 1'b0;
            r_clr       <= 1'b1;
        end else begin
            r_clr     <= w_clear_p;
            r_tick    <= 1'b0;
            r_inc_sec <= 1'b0;
            r_inc_min <= 1'b0;
            // Tick phase is only held outside RUN so a resume keeps the sub-second position.
            if (w_clear_p) begin
                r_tick_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                if (r_tick_cnt == TICK_MAX) begin
                    r_tick_cnt <= '0;
                    r_tick     <= 1'b1;
                end else begin
                    r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                end
            end
            if (w_clear_p || w_adj_entry) begin
                r_adj_cnt <= '0;
            end else if (r_state == ST_ADJUST) begin
                if (r_adj_cnt == ADJ_MAX) begin
                    r_adj_cnt <= '0;
                    r_inc_sec <= w_sel_s;
                    r_inc_min <= ~w_sel_s;
                end else begin
                    r_adj_cnt <= r_adj_cnt + ADJ_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
            r_blank_sec <= 1'b0;
            r_blank_min <= 1'b0;
            r_scan_cnt  <= '0;
            r_digit     <= DIG_SEC_ONES;
        end else begin
            r_blank_sec <= (r_state == ST_ADJUST) && w_sel_s && !r_blink;
            r_blank_min <= (r_state == ST_ADJUST) && !w_sel_s && !r_blink;
            if (r_state != ST_ADJUST) begin
                r_blink     <= 1'b1;
                r_blink_cnt <= '0;
            end else if (r_blink_cnt == BLINK_MAX) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
            if (r_scan_cnt == SCAN_MAX) begin
                r_scan_cnt <= '0;
                r_digit    <= (r_digit == DIG_MIN_TENS) ? DIG_SEC_ONES : r_digit + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
        end
    end

    assign io.TICK      = r_tick;
    assign io.INC_SEC   = r_inc_sec;
    assign io.INC_MIN   = r_inc_min;
    assign io.CLR_CNT   = r_clr;
    assign io.DIGIT_SEL = r_digit;
    assign io.BLANK_SEC = r_blank_sec;
    assign io.BLANK_MIN = r_blank_min;
    assign io.STATE     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with a behavioural reference model
module tb_stopwatch_ctrl;

    localparam int TICK_DIV  = 10;
    localparam int ADJ_DIV   = 5;
    localparam int BLINK_DIV = 3;
    localparam int SCAN_DIV  = 4;
    localparam int DB        = 4;

    localparam int M_RUN = 0, M_PAUSED = 1, M_ADJUST = 2;

    typedef struct {
        bit tick;
        bit inc_sec;
        bit inc_min;
        bit clr;
        int digit;
        bit bs;
        bit bm;
        int st;
    } exp_t;

    logic clk;
    logic rst;
    logic pause_btn, clear_btn, adj, sel;

    stopwatch_ctrl_if io();

    assign io.PAUSE_BTN = pause_btn;
    assign io.CLEAR_BTN = clear_btn;
    assign io.ADJ       = adj;
    assign io.SEL       = sel;

    stopwatch_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .ADJ_DIV   (ADJ_DIV),
        .BLINK_DIV (BLINK_DIV),
        .SCAN_DIV  (SCAN_DIV),
        .DB_CYCLES (DB)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t q[$];
    exp_t mon_e;
    bit   model_on = 1'b1;

    // Reference model state: raw-input history queues, debounce windows, elapsed-cycle phases.
    bit   sq[4][$];
    bit   win[2][$];
    bit   lvl[2];
    bit   rose[2];
    bit   stg[2];
    int   m_mode, m_resume, m_tphase, m_aphase, m_bphase, m_cycles;
    bit   m_blink;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
        end
    endtask

    initial begin
        exp_t e;
        bit   raw[4];
        bit   s[4];
        bit   pp, cp, all_diff, entry;
        forever begin
            @(posedge clk);
            if (model_on) begin
                if (rst) begin
                    for (int i = 0; i < 4; i++) begin
                        sq[i].delete();
                        sq[i].push_back(1'b0);
                        sq[i].push_back(1'b0);
                    end
                    for (int b = 0; b < 2; b++) begin
                        win[b].delete();
                        lvl[b] = 0; rose[b] = 0; stg[b] = 0;
                    end
                    m_mode = M_RUN; m_resume = M_RUN;
                    m_tphase = 0; m_aphase = 0; m_bphase = 0; m_cycles = 0;
                    m_blink = 1'b1;
                    e = '{tick: 0, inc_sec: 0, inc_min: 0, clr: 1, digit: 0, bs: 0, bm: 0, st: M_RUN};
                end else begin
                    raw = '{pause_btn, clear_btn, adj, sel};
                    for (int i = 0; i < 4; i++) begin
                        s[i] = sq[i].pop_front();
                        sq[i].push_back(raw[i]);
                    end
                    pp = stg[0];
                    cp = stg[1];
                    for (int b = 0; b < 2; b++) begin
                        stg[b]  = rose[b];
                        rose[b] = 0;
                        win[b].push_back(s[b]);
                        if (win[b].size() > DB) void'(win[b].pop_front());
                        all_diff = (win[b].size() == DB);
                        for (int j = 0; j < win[b].size(); j++)
                            if (win[b][j] == lvl[b]) all_diff = 0;
                        if (all_diff) begin
                            lvl[b]  = !lvl[b];
                            rose[b] = lvl[b];
                            win[b].delete();
                        end
                    end
                    e.clr     = cp;
                    e.bs      = (m_mode == M_ADJUST) && s[3] && !m_blink;
                    e.bm      = (m_mode == M_ADJUST) && !s[3] && !m_blink;
                    e.tick    = 0;
                    e.inc_sec = 0;
                    e.inc_min = 0;
                    if (cp) m_tphase = 0;
                    else if (m_mode == M_RUN) begin
                        m_tphase = (m_tphase + 1) % TICK_DIV;
                        e.tick   = (m_tphase == 0);
                    end
                    entry = (m_mode != M_ADJUST) && s[2];
                    if (cp || entry) m_aphase = 0;
                    else if (m_mode == M_ADJUST) begin
                        m_aphase = (m_aphase + 1) % ADJ_DIV;
                        if (m_aphase == 0) begin
                            e.inc_sec = s[3];
                            e.inc_min = !s[3];
                        end
                    end
                    if (m_mode != M_ADJUST) begin
                        m_blink = 1; m_bphase = 0;
                    end else begin
                        m_bphase = (m_bphase + 1) % BLINK_DIV;
                        if (m_bphase == 0) m_blink = !m_blink;
                    end
                    m_cycles++;
                    e.digit = (m_cycles / SCAN_DIV) % 4;
                    if (m_mode != M_ADJUST) begin
                        if (s[2]) begin
                            m_resume = pp ? (1 - m_mode) : m_mode;
                            m_mode   = M_ADJUST;
                        end else if (pp) m_mode = 1 - m_mode;
                    end else begin
                        if (!s[2]) m_mode = pp ? (1 - m_resume) : m_resume;
                        else if (pp) m_resume = 1 - m_resume;
                    end
                    e.st = m_mode;
                end
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("TICK",      int'(io.TICK),      int'(mon_e.tick));
                chk("INC_SEC",   int'(io.INC_SEC),   int'(mon_e.inc_sec));
                chk("INC_MIN",   int'(io.INC_MIN),   int'(mon_e.inc_min));
                chk("CLR_CNT",   int'(io.CLR_CNT),   int'(mon_e.clr));
                chk("DIGIT_SEL", int'(io.DIGIT_SEL), mon_e.digit);
                chk("BLANK_SEC", int'(io.BLANK_SEC), int'(mon_e.bs));
                chk("BLANK_MIN", int'(io.BLANK_MIN), int'(mon_e.bm));
                chk("STATE",     int'(io.STATE),     mon_e.st);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_pause(input int hold, input int after);
        pause_btn = 1'b1;
        cyc(hold);
        pause_btn = 1'b0;
        cyc(after);
    endtask

    initial begin
        int guard;
        rst = 1'b1; pause_btn = 0; clear_btn = 0; adj = 0; sel = 0;
        cyc(2);
        rst = 1'b0;
        cyc(35);

        // Pause mid tick period, hold, then resume.
        press_pause(10, 15);
        press_pause(10, 20);

        for (int g = 1; g <= 3; g++) press_pause(g, 6);

        adj = 1'b1; sel = 1'b1;
        cyc(20);
        sel = 1'b0;
        cyc(15);
        adj = 1'b0;
        cyc(10);

        // Time the clear so its pulse lands on the tick prescaler wrap.
        guard = 0;
        while (!(m_mode == M_RUN && m_tphase == 2) && guard < 50) begin
            cyc(1);
            guard++;
        end
        chk("clear_align_wait", guard < 50 ? 1 : 0, 1);
        clear_btn = 1'b1;
        cyc(6);
        clear_btn = 1'b0;
        cyc(15);

        press_pause(8, 6);
        adj = 1'b1;
        cyc(5);
        press_pause(8, 6);
        adj = 1'b0;
        cyc(5);
        pause_btn = 1'b1;
        cyc(3);
        rst = 1'b1;
        pause_btn = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(20);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0)   pause_btn = ~pause_btn;
            if ($urandom_range(0, 15) == 0)  clear_btn = ~clear_btn;
            if ($urandom_range(0, 59) == 0)  adj = ~adj;
            if ($urandom_range(0, 19) == 0)  sel = ~sel;
            rst = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(5);

        model_on = 1'b0;
        cyc(3);
        chk("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
